// File: rtl/multi_mode_ff_bank.sv
// -----------------------------------------------------------------------------
// multi_mode_ff_bank
//   A bank of WIDTH flip-flops whose per-edge update rule is chosen at run
//   time from SR, JK, D or T. The bank also watches for the forbidden SR input
//   (S=R=1). Each bit that sees it sets a sticky flag, and a saturating counter
//   counts the clock edges on which at least one such conflict occurred.
//
// Parameters
//   WIDTH        number of flip-flops
//   RST_VAL      value loaded into q on reset
//   SR_CONFLICT  SR-mode action for S=R=1: 0 hold, 1 set wins, 2 reset wins
//                (any other value behaves as hold)
//   CNT_W        width of err_cnt_o
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en_i       update enable
//   mode_i     00 SR, 01 JK, 10 D, 11 T
//   a_i        S / J / D / T per bit
//   b_i        R / K per bit (ignored in D and T modes)
//   clr_err_i  synchronous clear of err_o / err_cnt_o
//   q_o        registered state
//   qn_o       combinational ~q_o
//   err_o      sticky per-bit SR-conflict flags
//   err_cnt_o  saturating count of edges with at least one conflict
// -----------------------------------------------------------------------------
module multi_mode_ff_bank #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RST_VAL     = '0,
  parameter int               SR_CONFLICT = 0,
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qn_o,
  output logic [WIDTH-1:0] err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] conflict;
  logic             any_conflict;
  logic [WIDTH-1:0] sr_set, sr_clr, sr_next;

  // Conflicts only exist when the SR rule is actually being applied.
  assign conflict     = (en_i && (mode_i == MODE_SR)) ? (a_i & b_i) : '0;
  assign any_conflict = |conflict;

  // Unambiguous set/clear first; conflicting bits then resolved by policy.
  assign sr_set = a_i & ~b_i;
  assign sr_clr = b_i & ~a_i;

  always_comb begin
    sr_next = (q_q & ~sr_clr) | sr_set;
    if (SR_CONFLICT == 1) begin
      sr_next = sr_next | (a_i & b_i);
    end else if (SR_CONFLICT == 2) begin
      sr_next = sr_next & ~(a_i & b_i);
    end
  end

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      case (mode_i)
        MODE_SR: q_d = sr_next;
        MODE_JK: q_d = (a_i & ~q_q) | (~b_i & q_q);
        MODE_D:  q_d = a_i;
        MODE_T:  q_d = q_q ^ a_i;
        default: q_d = q_q;
      endcase
    end
  end

  // A conflict on the same edge as a clear survives the clear.
  always_comb begin
    err_d = err_q | conflict;
    cnt_d = cnt_q;
    if (clr_err_i) begin
      err_d = conflict;
      cnt_d = any_conflict ? CNT_ONE : '0;
    end else if (any_conflict && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= RST_VAL;
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign q_o       = q_q;
  assign qn_o      = ~q_q;
  assign err_o     = err_q;
  assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// -----------------------------------------------------------------------------
// tb_multi_mode_ff_bank
//   Four instances share one set of inputs:
//     u0: SR_CONFLICT=0, CNT_W=8   u1: SR_CONFLICT=1   u2: SR_CONFLICT=2
//     u3: SR_CONFLICT=0, CNT_W=2   (all RST_VAL=4'b1010)
//   Stimulus pushes the expected response into a queue shortly after each edge.
//   A monitor pops one entry on the following falling edge and compares it.
// -----------------------------------------------------------------------------
module tb_multi_mode_ff_bank;

  localparam logic [1:0] SR = 2'b00;
  localparam logic [1:0] JK = 2'b01;
  localparam logic [1:0] D  = 2'b10;
  localparam logic [1:0] T  = 2'b11;

  typedef struct {
    string      tag;
    logic [3:0] q0, q1, q2;
    logic [3:0] err;
    logic [7:0] cnt0;
    logic [1:0] cnt3;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic [1:0] mode = D;
  logic [3:0] a = '0, b = '0;

  logic [3:0] q0, qn0, err0, q1, qn1, err1, q2, qn2, err2, q3, qn3, err3;
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_mode_ff_bank #(.WIDTH(4), .RST_VAL(4'b1010), .SR_CONFLICT(0), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .en_i(en), .mode_i(mode), .a_i(a), .b_i(b), .clr_err_i(clr),
    .q_o(q0), .qn_o(qn0), .err_o(err0), .err_cnt_o(cnt0));
  multi_mode_ff_bank #(.WIDTH(4), .RST_VAL(4'b1010), .SR_CONFLICT(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .en_i(en), .mode_i(mode), .a_i(a), .b_i(b), .clr_err_i(clr),
    .q_o(q1), .qn_o(qn1), .err_o(err1), .err_cnt_o(cnt1));
  multi_mode_ff_bank #(.WIDTH(4), .RST_VAL(4'b1010), .SR_CONFLICT(2), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .en_i(en), .mode_i(mode), .a_i(a), .b_i(b), .clr_err_i(clr),
    .q_o(q2), .qn_o(qn2), .err_o(err2), .err_cnt_o(cnt2));
  multi_mode_ff_bank #(.WIDTH(4), .RST_VAL(4'b1010), .SR_CONFLICT(0), .CNT_W(2)) u3 (
    .clk(clk), .rst(rst), .en_i(en), .mode_i(mode), .a_i(a), .b_i(b), .clr_err_i(clr),
    .q_o(q3), .qn_o(qn3), .err_o(err3), .err_cnt_o(cnt3));

  task automatic chk(input string tag, input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  // Monitor: one expected entry per falling edge after it was posted.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.tag, "q0",   {4'b0, q0},   {4'b0, e.q0});
        chk(e.tag, "qn0",  {4'b0, qn0},  {4'b0, ~e.q0});
        chk(e.tag, "q1",   {4'b0, q1},   {4'b0, e.q1});
        chk(e.tag, "qn1",  {4'b0, qn1},  {4'b0, ~e.q1});
        chk(e.tag, "q2",   {4'b0, q2},   {4'b0, e.q2});
        chk(e.tag, "q3",   {4'b0, q3},   {4'b0, e.q0});
        chk(e.tag, "err0", {4'b0, err0}, {4'b0, e.err});
        chk(e.tag, "err1", {4'b0, err1}, {4'b0, e.err});
        chk(e.tag, "err2", {4'b0, err2}, {4'b0, e.err});
        chk(e.tag, "err3", {4'b0, err3}, {4'b0, e.err});
        chk(e.tag, "cnt0", cnt0, e.cnt0);
        chk(e.tag, "cnt1", cnt1, e.cnt0);
        chk(e.tag, "cnt2", cnt2, e.cnt0);
        chk(e.tag, "cnt3", {6'b0, cnt3}, {6'b0, e.cnt3});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic post(input string tag, input logic [3:0] eq0, eq1, eq2, eerr,
                      input logic [7:0] ec0, input logic [1:0] ec3);
    exp_t e;
    e.tag = tag; e.q0 = eq0; e.q1 = eq1; e.q2 = eq2;
    e.err = eerr; e.cnt0 = ec0; e.cnt3 = ec3;
    sb.push_back(e);
  endtask

  task automatic step(input string tag, input logic [1:0] m, input logic e_in,
                      input logic [3:0] av, bv, input logic c,
                      input logic [3:0] eq0, eq1, eq2, eerr,
                      input logic [7:0] ec0, input logic [1:0] ec3);
    @(negedge clk);
    mode = m; en = e_in; a = av; b = bv; clr = c;
    @(posedge clk);
    #1 post(tag, eq0, eq1, eq2, eerr, ec0, ec3);
  endtask

  // Reference model written per bit from the mode truth tables.
  function automatic logic [3:0] ref_next(input logic [3:0] q, input logic [1:0] m,
                                          input logic [3:0] av, bv, input int sc);
    logic [3:0] n;
    for (int i = 0; i < 4; i++) begin
      n[i] = q[i];
      case (m)
        SR: begin
          if (av[i] && !bv[i]) n[i] = 1'b1;
          else if (!av[i] && bv[i]) n[i] = 1'b0;
          else if (av[i] && bv[i]) n[i] = (sc == 1) ? 1'b1 : (sc == 2) ? 1'b0 : q[i];
        end
        JK: case ({av[i], bv[i]})
          2'b10: n[i] = 1'b1;
          2'b01: n[i] = 1'b0;
          2'b11: n[i] = ~q[i];
          default: n[i] = q[i];
        endcase
        D: n[i] = av[i];
        T: if (av[i]) n[i] = ~q[i];
        default: n[i] = q[i];
      endcase
    end
    return n;
  endfunction

  initial begin
    logic [3:0] mq0, mq1, mq2, merr, ra, rb, cv;
    logic [1:0] rm;
    logic       ren;
    int         mc0, mc3, sr_edges;

    // Reset asserted from time 0, released mid-cycle.
    #1 post("reset0", 4'b1010, 4'b1010, 4'b1010, 4'b0000, 8'd0, 2'd0);
    #6 rst = 1'b0;

    step("d_load",   D, 1, 4'b0101, 4'b0000, 0, 4'b0101, 4'b0101, 4'b0101, 4'b0000, 8'd0, 2'd0);

    // Async reset 2 units after an edge; checked before the next edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 post("async_rst", 4'b1010, 4'b1010, 4'b1010, 4'b0000, 8'd0, 2'd0);
    step("rst_held", SR, 1, 4'b1111, 4'b1111, 1, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 8'd0, 2'd0);
    @(negedge clk);
    mode = D; en = 1'b1; a = 4'b1111; b = 4'b0000; clr = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1 post("rst_rel", 4'b1111, 4'b1111, 4'b1111, 4'b0000, 8'd0, 2'd0);

    // D ignores b: no conflict even with a=b=1111.
    step("d_gate",   D,  1, 4'b1111, 4'b1111, 0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 8'd0, 2'd0);
    step("d_zero",   D,  1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0, 2'd0);
    step("sr_set",   SR, 1, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 8'd0, 2'd0);
    // bit0 conflict (hold/set/reset), bit1 set, bit3 clear.
    step("sr_conf",  SR, 1, 4'b0011, 4'b1001, 0, 4'b0011, 4'b0011, 4'b0010, 4'b0001, 8'd1, 2'd1);
    step("d_zero2",  D,  1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 8'd1, 2'd1);
    step("jk_tog1",  JK, 1, 4'b1111, 4'b1111, 0, 4'b1111, 4'b1111, 4'b1111, 4'b0001, 8'd1, 2'd1);
    step("jk_tog2",  JK, 1, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 8'd1, 2'd1);
    step("jk_tog3",  JK, 1, 4'b1111, 4'b1111, 0, 4'b1111, 4'b1111, 4'b1111, 4'b0001, 8'd1, 2'd1);
    step("t_tog",    T,  1, 4'b0101, 4'b0000, 0, 4'b1010, 4'b1010, 4'b1010, 4'b0001, 8'd1, 2'd1);
    step("t_en0",    T,  0, 4'b1111, 4'b0000, 0, 4'b1010, 4'b1010, 4'b1010, 4'b0001, 8'd1, 2'd1);
    step("sr_en0",   SR, 0, 4'b1111, 4'b1111, 0, 4'b1010, 4'b1010, 4'b1010, 4'b0001, 8'd1, 2'd1);
    step("clr_d",    D,  1, 4'b1010, 4'b0000, 1, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 8'd0, 2'd0);

    // Saturation of the 2-bit counter in u3.
    step("sat1", SR, 1, 4'b0001, 4'b0001, 0, 4'b1010, 4'b1011, 4'b1010, 4'b0001, 8'd1, 2'd1);
    step("sat2", SR, 1, 4'b0001, 4'b0001, 0, 4'b1010, 4'b1011, 4'b1010, 4'b0001, 8'd2, 2'd2);
    step("sat3", SR, 1, 4'b0001, 4'b0001, 0, 4'b1010, 4'b1011, 4'b1010, 4'b0001, 8'd3, 2'd3);
    step("sat4", SR, 1, 4'b0001, 4'b0001, 0, 4'b1010, 4'b1011, 4'b1010, 4'b0001, 8'd4, 2'd3);
    step("sat5", SR, 1, 4'b0001, 4'b0001, 0, 4'b1010, 4'b1011, 4'b1010, 4'b0001, 8'd5, 2'd3);
    step("clr_noc",  SR, 1, 4'b0000, 4'b0000, 1, 4'b1010, 4'b1011, 4'b1010, 4'b0000, 8'd0, 2'd0);
    step("clr_conf", SR, 1, 4'b0100, 4'b0100, 1, 4'b1010, 4'b1111, 4'b1010, 4'b0100, 8'd1, 2'd1);
    // Four conflicting bits still count as a single event.
    step("multi",    SR, 1, 4'b1111, 4'b1111, 0, 4'b1010, 4'b1111, 4'b0000, 4'b1111, 8'd2, 2'd2);

    // Reset again, then a randomized run cycling the mode every edge.
    @(negedge clk);
    en = 1'b0; clr = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 post("reset2", 4'b1010, 4'b1010, 4'b1010, 4'b0000, 8'd0, 2'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    mq0 = 4'b1010; mq1 = 4'b1010; mq2 = 4'b1010; merr = '0;
    mc0 = 0; mc3 = 0; sr_edges = 0;
    for (int i = 0; i < 200; i++) begin
      rm  = 2'(i % 4);
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      ren = ($urandom_range(0, 7) != 0);
      @(negedge clk);
      mode = rm; en = ren; a = ra; b = rb; clr = 1'b0;
      if (ren) begin
        mq0 = ref_next(mq0, rm, ra, rb, 0);
        mq1 = ref_next(mq1, rm, ra, rb, 1);
        mq2 = ref_next(mq2, rm, ra, rb, 2);
      end
      cv = (ren && rm == SR) ? (ra & rb) : 4'b0000;
      merr = merr | cv;
      if (cv != 4'b0000) begin
        sr_edges++;
        if (mc0 < 255) mc0++;
        if (mc3 < 3) mc3++;
      end
      @(posedge clk);
      #1 post("rand", mq0, mq1, mq2, merr, 8'(mc0), 2'(mc3));
    end

    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("final", "queue_empty", 8'(sb.size()), 8'd0);
    chk("final", "sr_edge_count", cnt0, 8'(sr_edges));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
